// File: rtl/rom_channel_scheduler_pkg.sv
// Shared types for the ROM channel scheduler: FSM states, ROM latency and
// the per-stage pipeline tag.
package rom_channel_scheduler_pkg;

  localparam int ROM_LATENCY = 1;
  localparam int CH_TAG_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_TAG_W-1:0] ch;
  } stage_t;

endpackage

// File: rtl/rom_channel_scheduler_phase_acc_bank.sv
// Per-channel phase accumulators and frequency control words, with a config
// write/clear port and an issue-increment port for the scheduled slot.
module rom_channel_scheduler_phase_acc_bank #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24,
  parameter int AW     = 8,
  parameter int CHW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we_i,
  input  logic [CHW-1:0]   cfg_ch_i,
  input  logic [ACC_W-1:0] cfg_fcw_i,
  input  logic             cfg_acc_clr_i,
  input  logic             inc_en_i,
  input  logic [CHW-1:0]   sel_i,
  output logic [AW-1:0]    phase_o
);

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] fcw_q [NUM_CH];

  // Channel selects outside 0..NUM_CH-1 never match, so such writes are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        fcw_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we_i && int'(cfg_ch_i) == c) begin
          fcw_q[c] <= cfg_fcw_i;
        end
        if (cfg_we_i && cfg_acc_clr_i && int'(cfg_ch_i) == c) begin
          acc_q[c] <= '0;
        end else if (inc_en_i && int'(sel_i) == c) begin
          acc_q[c] <= acc_q[c] + fcw_q[c];
        end
      end
    end
  end

  always_comb begin
    phase_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(sel_i) == c) phase_o = acc_q[c][ACC_W-1 -: AW];
    end
  end

endmodule

// File: rtl/rom_channel_scheduler.sv
// Time-multiplexes one registered waveform ROM between NUM_CH phase
// accumulator channels; one slot per cycle per frame, tagged samples out.
module rom_channel_scheduler
  import rom_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ROMSIZE = 256,
  parameter int ACC_W   = 24,
  parameter int DATA_W  = 16,
  localparam int AW     = $clog2(ROMSIZE),
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]  cfg_fcw,
  input  logic              cfg_acc_clr,
  output logic [AW-1:0]     rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  output logic [DATA_W-1:0] out_sample,
  output logic              busy,
  output logic              frame_overrun
);

  localparam int DRAIN_CYC = ROM_LATENCY + 1;

  sched_state_t      state_q, state_d;
  logic [CHW-1:0]    slot_q, slot_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [1:0]        drain_q, drain_d;
  logic              slot_en, issue_fire;
  logic [AW-1:0]     phase;
  stage_t            p0_d, p0_q, p1_q;
  logic [AW-1:0]     rom_address_q;
  logic              out_valid_q, overrun_q;
  logic [CHW-1:0]    out_ch_q;
  logic [DATA_W-1:0] out_sample_q;
  logic              unused_tag;

  rom_channel_scheduler_phase_acc_bank #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .AW(AW), .CHW(CHW)
  ) u_acc_bank (
    .clk          (clk),
    .reset        (reset),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_fcw_i    (cfg_fcw),
    .cfg_acc_clr_i(cfg_acc_clr),
    .inc_en_i     (issue_fire),
    .sel_i        (slot_q),
    .phase_o      (phase)
  );

  assign busy = (state_q != ST_IDLE) | p0_q.valid | p1_q.valid | out_valid_q;

  always_comb begin
    slot_en = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(slot_q) == c) slot_en = en_q[c];
    end
  end

  assign issue_fire = (state_q == ST_ISSUE) && slot_en;

  // Slots are consumed at a fixed rate even when disabled, so timing never depends on the mask.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    en_d    = en_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick && !busy) begin
          en_d    = ch_enable;
          slot_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (int'(slot_q) == NUM_CH - 1) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (int'(drain_q) == DRAIN_CYC - 1) state_d = ST_IDLE;
        else                                drain_d = drain_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    p0_d       = '0;
    p0_d.valid = issue_fire;
    p0_d.ch    = CH_TAG_W'(slot_q);
  end

  assign unused_tag = ^p1_q.ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      en_q          <= '0;
      drain_q       <= '0;
      p0_q          <= '0;
      p1_q          <= '0;
      rom_address_q <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_sample_q  <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      en_q      <= en_d;
      drain_q   <= drain_d;
      overrun_q <= sample_tick & busy;
      // p0: address issued to the ROM
      p0_q <= p0_d;
      if (issue_fire) rom_address_q <= phase;
      // p1: ROM output register holds the data
      p1_q <= p0_q;
      // p2: tagged sample presented to the sinks
      out_valid_q <= p1_q.valid;
      if (p1_q.valid) begin
        out_ch_q     <= p1_q.ch[CHW-1:0];
        out_sample_q <= rom_data;
      end
    end
  end

  assign rom_address   = rom_address_q;
  assign out_valid     = out_valid_q;
  assign out_ch        = out_ch_q;
  assign out_sample    = out_sample_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_rom_channel_scheduler.sv
// Scoreboard bench for rom_channel_scheduler with a registered {addr,addr} ROM model.
module tb_rom_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 24;
  localparam int DATA_W = 16;
  localparam int AW     = 8;
  localparam int CHW    = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_tick = 1'b0;
  logic [NUM_CH-1:0] ch_enable = '0;
  logic              cfg_we = 1'b0;
  logic [CHW-1:0]    cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_fcw = '0;
  logic              cfg_acc_clr = 1'b0;
  logic [AW-1:0]     rom_address;
  logic [DATA_W-1:0] rom_data = '0;
  logic              out_valid;
  logic [CHW-1:0]    out_ch;
  logic [DATA_W-1:0] out_sample;
  logic              busy;
  logic              frame_overrun;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] smp;
    int                cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [ACC_W-1:0] acc_m [NUM_CH];
  logic [ACC_W-1:0] fcw_m [NUM_CH];
  int               n_chk = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               vld_cnt = 0;
  int               ovr_cnt = 0;
  logic             mon_en = 1'b0;

  rom_channel_scheduler #(
    .NUM_CH(NUM_CH), .ROMSIZE(256), .ACC_W(ACC_W), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .ch_enable    (ch_enable),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_fcw      (cfg_fcw),
    .cfg_acc_clr  (cfg_acc_clr),
    .rom_address  (rom_address),
    .rom_data     (rom_data),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_sample   (out_sample),
    .busy         (busy),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rom_data <= {rom_address, rom_address};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (frame_overrun) ovr_cnt++;
      if (out_valid) begin
        vld_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("out_ch@%0d", cyc), 32'(out_ch), 32'(mon_e.ch));
          chk($sformatf("out_sample_ch%0d@%0d", mon_e.ch, cyc), 32'(out_sample), 32'(mon_e.smp));
          chk($sformatf("latency_ch%0d", mon_e.ch), 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input logic [ACC_W-1:0] fcw, input logic clr);
    cfg_we      = 1'b1;
    cfg_ch      = CHW'(ch);
    cfg_fcw     = fcw;
    cfg_acc_clr = clr;
    @(negedge clk);
    cfg_we      = 1'b0;
    cfg_acc_clr = 1'b0;
    fcw_m[ch]   = fcw;
    if (clr) acc_m[ch] = '0;
  endtask

  // Tick is sampled at edge cyc+1; channel c appears after edge E+3+c with the pre-increment phase.
  task automatic do_tick();
    int   e_edge;
    exp_t e;
    sample_tick = 1'b1;
    e_edge      = cyc + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_enable[c]) begin
        e.ch  = c;
        e.smp = {2{acc_m[c][ACC_W-1 -: AW]}};
        e.cyc = e_edge + 3 + c;
        sb.push_back(e);
        acc_m[c] = acc_m[c] + fcw_m[c];
      end
    end
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic tick_raw();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_rom_address"}, 32'(rom_address), 32'd0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_ch"}, 32'(out_ch), 32'd0);
    chk({pfx, "_out_sample"}, 32'(out_sample), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_frame_overrun"}, 32'(frame_overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, o0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_m[c] = '0;
      fcw_m[c] = '0;
    end
    #1 reset = 1'b1;
    step(2);
    chk_outputs_zero("por");
    reset  = 1'b0;
    mon_en = 1'b1;
    step(5);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_vld_cnt", 32'(vld_cnt), 32'd0);

    // Single channel, three frames
    cfg_write(0, 24'h010000, 1'b0);
    ch_enable = 4'b0001;
    repeat (3) begin
      do_tick();
      step(9);
    end
    #1;
    chk("single_vld_cnt", 32'(vld_cnt), 32'd3);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    // All channels, distinct FCWs
    for (int c = 0; c < NUM_CH; c++) cfg_write(c, ACC_W'((c + 1) * 32'h010000), 1'b1);
    ch_enable = 4'b1111;
    repeat (3) begin
      do_tick();
      step(9);
    end
    #1;
    chk("all_vld_cnt", 32'(vld_cnt), 32'd15);
    chk("all_sb_empty", 32'(sb.size()), 32'd0);

    // Half-scale FCW wraps; sparse enable mask
    cfg_write(2, 24'h800000, 1'b1);
    ch_enable = 4'b0101;
    repeat (4) begin
      do_tick();
      step(9);
    end
    #1;
    chk("mask_vld_cnt", 32'(vld_cnt), 32'd23);
    chk("mask_sb_empty", 32'(sb.size()), 32'd0);

    // Tick while busy is dropped
    ch_enable = 4'b1111;
    v0 = vld_cnt;
    o0 = ovr_cnt;
    do_tick();
    #1;
    chk("busy_in_frame", 32'(busy), 32'd1);
    step(1);
    tick_raw();
    step(9);
    #1;
    chk("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("overrun_vld_cnt", 32'(vld_cnt - v0), 32'd4);
    do_tick();
    step(9);

    // Clear ch1 on the same edge that issues ch1
    do_tick();
    step(1);
    cfg_write(1, fcw_m[1], 1'b1);
    step(8);
    do_tick();
    step(9);
    #1;
    chk("collide_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a frame
    do_tick();
    step(3);
    #2 reset = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    sb.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      acc_m[c] = '0;
      fcw_m[c] = '0;
    end
    step(2);
    reset = 1'b0;
    v0 = vld_cnt;
    step(8);
    #1;
    chk("post_rst_vld_cnt", 32'(vld_cnt - v0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
